// File: rtl/fp_atan2_cordic_if.sv
// fp_atan2_cordic_if
//   Request/response bundle for the atan2 CORDIC unit.
//   master : requester (drives start, x, y; observes busy, done, result, invalid)
//   slave  : the atan2 unit
//   start  : request, honoured only while busy=0
//   x, y   : IEEE-754 single operands (abscissa, ordinate)
//   busy   : unit is not idle
//   done   : one-cycle pulse when result/invalid are valid
//   result : IEEE-754 single atan2(y, x) in radians
//   invalid: result is the canonical NaN produced by a NaN/Inf operand
interface fp_atan2_cordic_if;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;

    modport master (output start, x, y, input busy, done, result, invalid);
    modport slave  (input start, x, y, output busy, done, result, invalid);
endinterface

// File: rtl/fp_atan2_cordic.sv
// fp_atan2_cordic
//   Sequential single-precision atan2(y, x) using a CORDIC vectoring loop.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     io    : fp_atan2_cordic_if.slave (start/x/y in, busy/done/result/invalid out)
//   Flow: IDLE -> ALIGN -> ITER (ITER steps) -> NORM -> DONE -> IDLE, or
//   IDLE -> DONE directly when an operand pair is a special case.
module fp_atan2_cordic #(
    parameter int ITER = 24,
    parameter int ZW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_atan2_cordic_if.slave io
);
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ITER, S_NORM, S_DONE} state_t;

    // Angle accumulator is Q3.28: FRAC fractional bits.
    localparam int FRAC = ZW - 4;
    localparam logic signed [ZW-1:0] PI_Z = ZW'(32'sh3243F6A9);

    // atan(2^-i) in Q3.28, rounded to nearest.
    function automatic logic signed [ZW-1:0] atan_tab(input logic [4:0] i);
        case (i)
            5'd0:  return ZW'(32'sd210828714);
            5'd1:  return ZW'(32'sd124459457);
            5'd2:  return ZW'(32'sd65760959);
            5'd3:  return ZW'(32'sd33381290);
            5'd4:  return ZW'(32'sd16755422);
            5'd5:  return ZW'(32'sd8385879);
            5'd6:  return ZW'(32'sd4193963);
            5'd7:  return ZW'(32'sd2097109);
            5'd8:  return ZW'(32'sd1048571);
            5'd9:  return ZW'(32'sd524287);
            5'd10: return ZW'(32'sd262144);
            5'd11: return ZW'(32'sd131072);
            5'd12: return ZW'(32'sd65536);
            5'd13: return ZW'(32'sd32768);
            5'd14: return ZW'(32'sd16384);
            5'd15: return ZW'(32'sd8192);
            5'd16: return ZW'(32'sd4096);
            5'd17: return ZW'(32'sd2048);
            5'd18: return ZW'(32'sd1024);
            5'd19: return ZW'(32'sd512);
            5'd20: return ZW'(32'sd256);
            5'd21: return ZW'(32'sd128);
            5'd22: return ZW'(32'sd64);
            5'd23: return ZW'(32'sd32);
            default: return '0;
        endcase
    endfunction

    // Subnormals become a zero of the same sign.
    function automatic logic [31:0] flush(input logic [31:0] f);
        return (f[30:23] == 8'd0) ? {f[31], 31'd0} : f;
    endfunction

    state_t                 state_q, state_d;
    logic [31:0]            xa_q, xa_d, ya_q, ya_d;
    logic signed [29:0]     cx_q, cx_d, cy_q, cy_d;
    logic signed [ZW-1:0]   z_q, z_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [31:0]            result_q, result_d;
    logic                   invalid_q, invalid_d;
    logic                   done_q, done_d;

    // ---------------- operand alignment ----------------
    logic [7:0]             ex, ey, dexp;
    logic [23:0]            mx, my, mx_al, my_al;
    logic signed [29:0]     x0, y0, x_al, y_al;
    logic signed [ZW-1:0]   z_al;

    always_comb begin
        ex    = xa_q[30:23];
        ey    = ya_q[30:23];
        mx    = (ex != 8'd0) ? {1'b1, xa_q[22:0]} : 24'd0;
        my    = (ey != 8'd0) ? {1'b1, ya_q[22:0]} : 24'd0;
        mx_al = mx;
        my_al = my;
        dexp  = 8'd0;
        if (ex >= ey) begin
            dexp  = ex - ey;
            my_al = (dexp >= 8'd26) ? 24'd0 : (my >> dexp);
        end else begin
            dexp  = ey - ex;
            mx_al = (dexp >= 8'd26) ? 24'd0 : (mx >> dexp);
        end
        // Two guard bits below the mantissa absorb shift truncation in the loop.
        x0   = $signed({4'b0000, mx_al, 2'b00});
        y0   = $signed({4'b0000, my_al, 2'b00});
        x_al = xa_q[31] ? -x0 : x0;
        y_al = ya_q[31] ? -y0 : y0;
        z_al = '0;
        // Left half-plane: rotate by pi so the loop only sees X >= 0.
        if (xa_q[31]) begin
            x_al = -x_al;
            y_al = -y_al;
            z_al = ya_q[31] ? -PI_Z : PI_Z;
        end
    end

    // ---------------- angle to float ----------------
    logic [ZW-1:0] zmag, zshift;
    logic [4:0]    lead;
    logic [7:0]    nexp;
    logic [22:0]   nfrac;
    logic [31:0]   norm_res;

    always_comb begin
        zmag = z_q[ZW-1] ? -z_q : z_q;
        lead = 5'd0;
        for (int i = 0; i < ZW; i++) begin
            if (zmag[i]) lead = i[4:0];
        end
        // Leading one moves to the MSB; the 23 bits below it are the fraction.
        zshift   = zmag << (5'(ZW - 1) - lead);
        nfrac    = 23'(zshift >> (ZW - 24));
        nexp     = 8'(lead) + 8'(127 - FRAC);
        norm_res = (zmag == '0) ? 32'd0 : {z_q[ZW-1], nexp, nfrac};
    end

    // ---------------- control ----------------
    logic x_special, y_special, both_zero;
    assign x_special = &io.x[30:23];
    assign y_special = &io.y[30:23];
    assign both_zero = (io.x[30:23] == 8'd0) && (io.y[30:23] == 8'd0);

    always_comb begin
        state_d   = state_q;
        xa_d      = xa_q;
        ya_d      = ya_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        z_d       = z_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    invalid_d = 1'b0;
                    xa_d      = flush(io.x);
                    ya_d      = flush(io.y);
                    if (x_special || y_special) begin
                        result_d  = 32'h7FC0_0000;
                        invalid_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (both_zero) begin
                        result_d = 32'd0;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                cx_d    = x_al;
                cy_d    = y_al;
                z_d     = z_al;
                cnt_d   = 5'd0;
                state_d = S_ITER;
            end
            S_ITER: begin
                // Drive Y toward zero; Z accumulates the rotation applied.
                if (cy_q[29]) begin
                    cx_d = cx_q - (cy_q >>> cnt_q);
                    cy_d = cy_q + (cx_q >>> cnt_q);
                    z_d  = z_q - atan_tab(cnt_q);
                end else begin
                    cx_d = cx_q + (cy_q >>> cnt_q);
                    cy_d = cy_q - (cx_q >>> cnt_q);
                    z_d  = z_q + atan_tab(cnt_q);
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) state_d = S_NORM;
            end
            S_NORM: begin
                result_d = norm_res;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            xa_q      <= '0;
            ya_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            z_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xa_q      <= xa_d;
            ya_q      <= ya_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            z_q       <= z_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            done_q    <= done_d;
        end
    end

    assign io.busy    = (state_q != S_IDLE);
    assign io.done    = done_q;
    assign io.result  = result_q;
    assign io.invalid = invalid_q;
endmodule

// File: doc/fp_atan2_cordic.md
# fp_atan2_cordic

Sequential IEEE-754 single-precision two-argument arctangent, result = atan2(y, x) in radians. It is the inverse-direction companion of the combinational sine/cosine unit and recovers an angle from a (y, x) component pair. It uses a 24-iteration CORDIC vectoring loop behind a start/done handshake. It sits beside the other floating-point units in the FP library.

## Interface
- ITER, 24: CORDIC iterations; atan table has ITER entries.
- ZW, 32: angle accumulator width, signed Q3.28.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request; sampled only while busy=0.
- x  in  32  IEEE-754 single, abscissa.
- y  in  32  IEEE-754 single, ordinate.
- busy  out  1  high in every state except IDLE.
- done  out  1  high for exactly one cycle when result is valid.
- result  out  32  IEEE-754 single, atan2(y,x) in [-pi, +pi].
- invalid  out  1  set with done when a special case produced NaN.

## Operation
- States: IDLE, ALIGN, ITER, NORM, DONE. Transitions: IDLE→ALIGN on start, or IDLE→DONE on a special case. ALIGN→ITER. ITER→NORM after ITER steps. NORM→DONE. DONE→IDLE unconditionally.
- IDLE with start=1: latch x and y. Subnormals are flushed to signed zero.
- Special cases are decided in IDLE:
  - Either operand NaN or Inf: result=0x7FC00000, invalid=1.
  - Both operands zero (any signs): result=0x00000000, invalid=0.
- ALIGN:
  - Form 24-bit mantissas with the hidden bit. Shift the smaller-exponent mantissa right by the exponent difference; a difference ≥26 gives 0.
  - Place the mantissas in 30-bit signed X and Y at bits [25:2], apply operand signs, and set Z=0.
  - If x's sign bit is 1, negate X and Y. Then set Z=+pi (0x3243F6A9 in Q3.28) when y's sign bit is 0, else Z=−pi.
- ITER, step i = 0..ITER−1:
  - If Y<0: X−=Y>>>i, Y+=X>>>i, Z−=atan(2^-i).
  - Else: X+=Y>>>i, Y−=X>>>i, Z+=atan(2^-i).
  - Shifts are arithmetic and use pre-update values. The table is constant, Q3.28, rounded to nearest. Gain is not compensated; the angle does not need it.
- NORM:
  - Sign = Z[31]; magnitude = |Z|.
  - Find the leading one at position p: exponent = 127+p−28, fraction = the next 23 bits, truncated.
  - Magnitude 0 gives +0.
- result and invalid hold their value until the next accepted start. invalid is cleared on every accepted start.
- Accuracy: absolute error ≤2^-21 rad for all finite non-zero inputs.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, result=0x00000000, invalid=0.
- Start edge = E0. Latency counts from E0 to the edge at which done is sampled high.
  - Normal path: ALIGN at E0, ITER from E1, iterations on E2..E25, NORM at E25, DONE at E26. done is sampled high at E27: latency 27.
  - Special path: DONE at E0; done is sampled high at E1: latency 1.
- done = (state==DONE), registered. busy=1 from the cycle after E0 through the DONE cycle.
- start while busy=1 is ignored with no queueing. start in the DONE cycle is also ignored; the next start is accepted in IDLE.
- Back-to-back operation: at most one result every 28 cycles (normal) or 2 cycles (special).
- Reset asserted mid-operation: IDLE at that edge, no done pulse, result cleared to 0.
- Iteration counter: 5 bits, cleared in ALIGN. ITER→NORM when the counter equals ITER−1 at the edge.

## Test plan
- x=0x3F800000, y=0x3F800000 → done sampled at E27, result 0x3F490FDB (pi/4) within 4 ulp, invalid=0.
- x=0xBF800000 (−1), y=0x3F800000 → result 0x4016CBE4 (3pi/4) within 4 ulp. x=0xBF800000, y=0x00000000 → 0x40490FDB (+pi). y=0x80000000 → 0xC0490FDB (−pi).
- x=0x00000000, y=0xBF800000 → 0xBFC90FDB (−pi/2) within 4 ulp. x=0x3F800000, y=0x00000000 → |result| ≤2^-21.
- Specials:
  - x=0x7FFFFFFF (NaN) → done at E1, result 0x7FC00000, invalid=1.
  - y=0x7F800000 (Inf) → same response.
  - x=y=0x80000000 → done at E1, result 0x00000000, invalid=0.
- Handshake: start pulses at E0+5 and in the DONE cycle are ignored; there is exactly one done pulse and result is unchanged. A new start in IDLE is accepted and its done is sampled 27 edges later.
- Reset at E0+10 of a normal run → busy=0 and result=0x00000000 on the next cycle, and no done pulse appears for the next 30 cycles.
